// File: rtl/grf_sb.sv
// grf_sb: parametrised general register file with a per-register pending
// scoreboard for the pipelined core.
//   * Reads are combinational; a same-cycle writeback bypasses to every read port.
//   * Issue sets a pending bit, writeback clears it; when both hit the same
//     register in one cycle, the set wins.
//   * pend_cnt tracks the popcount of the pending bits and is updated
//     incrementally on each edge.
// Optional feature: define GRF_TRACE_EN to print one writeback trace line per
// committed write. Without it, wpc is unused.
module grf_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_pend,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic [31:0]           wpc,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [ADDR_W:0]       pend_cnt
);

    localparam int   NREG = 2 ** ADDR_W;
    localparam logic ZR   = (ZERO_REG != 32'sd0);

    // An out-of-range port count references a module that does not exist,
    // so elaboration stops with an error.
    generate
        if (NRD < 1 || NRD > 4) begin : g_bad_nrd
            grf_sb_nrd_out_of_range_error u_nrd_error ();
        end
    endgenerate

    logic [DATA_W-1:0] regs_r [NREG];
    logic [NREG-1:0]   pend_r;
    logic [ADDR_W:0]   pend_cnt_r;

    logic              wr_ok_s;
    logic              iss_ok_s;
    logic              rise_s;
    logic              fall_s;
    logic [NREG-1:0]   pend_nxt_s;

    // Qualify write and issue requests; register 0 is excluded when hardwired.
    always_comb begin
        wr_ok_s  = we && !(ZR && (wa == {ADDR_W{1'b0}}));
        iss_ok_s = iss_en && !(ZR && (iss_addr == {ADDR_W{1'b0}}));
    end

    // Next pending vector plus the 0->1 and 1->0 events that move the count.
    always_comb begin
        pend_nxt_s = pend_r;
        if (wr_ok_s) begin
            pend_nxt_s[wa] = 1'b0;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        if (iss_ok_s) begin
            pend_nxt_s[iss_addr] = 1'b1;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        rise_s = iss_ok_s && !pend_r[iss_addr];
        fall_s = wr_ok_s && pend_r[wa] && !(iss_ok_s && (iss_addr == wa));
    end

    // Register array: async clear, written on a qualified writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_r[wa] <= wd;
        end else begin
            regs_r[wa] <= regs_r[wa];
        end
    end

    // Scoreboard bits and their running count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r     <= '0;
            pend_cnt_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
            if (rise_s && !fall_s) begin
                pend_cnt_r <= pend_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            end else if (fall_s && !rise_s) begin
                pend_cnt_r <= pend_cnt_r - {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                pend_cnt_r <= pend_cnt_r;
            end
        end
    end

    assign pend_cnt = pend_cnt_r;

    // Read ports: hardwired zero, then writeback bypass, then stored value.
    // Forced to zero while reset is held so a stray bypass cannot leak out.
    always_comb begin
        rd      = '0;
        rd_pend = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!rst) begin
                rd[k*DATA_W +: DATA_W] = '0;
                rd_pend[k]             = 1'b0;
            end else if (ZR && (ra[k*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})) begin
                rd[k*DATA_W +: DATA_W] = '0;
                rd_pend[k]             = 1'b0;
            end else if (we && (wa == ra[k*ADDR_W +: ADDR_W])) begin
                rd[k*DATA_W +: DATA_W] = wd;
                rd_pend[k]             = 1'b0;
            end else begin
                rd[k*DATA_W +: DATA_W] = regs_r[ra[k*ADDR_W +: ADDR_W]];
                rd_pend[k]             = pend_r[ra[k*ADDR_W +: ADDR_W]];
            end
        end
    end

`ifdef GRF_TRACE_EN
    // Writeback trace in the course reference format.
    always @(posedge clk) begin
        if (rst && we && ((wa != {ADDR_W{1'b0}}) || !ZR)) begin
            $display("@%h: $%d <= %h", wpc, wa, wd);
        end else begin
        end
    end
`else
    logic unused_wpc_s;
    assign unused_wpc_s = ^wpc;
`endif

endmodule

// File: tb/tb_grf_sb.sv
// Self-checking bench for grf_sb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_grf_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NR  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NRD*AW-1:0] ra = '0;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rd_pend;
    logic              we = 1'b0;
    logic [AW-1:0]     wa = '0;
    logic [DW-1:0]     wd = '0;
    logic [31:0]       wpc = '0;
    logic              iss_en = 1'b0;
    logic [AW-1:0]     iss_addr = '0;
    logic [AW:0]       pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Behavioural model: plain arrays holding architectural state.
    logic [DW-1:0] m_reg [NR];
    bit            m_pend [NR];

    grf_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_pend(rd_pend),
        .we(we), .wa(wa), .wd(wd), .wpc(wpc),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update: architectural effect of one clock edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                m_reg[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    end

    // Compare process: every cycle, mid-period, outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < NR; i++) cnt += int'(m_pend[i]);
            chk("pend_cnt", 32'(pend_cnt), rst ? 32'(cnt) : 32'd0);
            for (int k = 0; k < NRD; k++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] e_rd;
                logic          e_p;
                a = ra[k*AW +: AW];
                if (!rst || a == 0) begin
                    e_rd = '0; e_p = 1'b0;
                end else if (we && wa == a) begin
                    e_rd = wd; e_p = 1'b0;
                end else begin
                    e_rd = m_reg[a]; e_p = m_pend[a];
                end
                chk($sformatf("rd%0d", k), rd[k*DW +: DW], e_rd);
                chk($sformatf("rd_pend%0d", k), 32'(rd_pend[k]), 32'(e_p));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic ie, input logic [AW-1:0] ia,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        we = w; wa = a; wd = d; iss_en = ie; iss_addr = ia;
        ra = {r1, r0};
        wpc = $urandom;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("reset_cnt", 32'(pend_cnt), 32'd0);
        chk("reset_rd0", rd[31:0], 32'd0);
        check_en = 1'b1;
        @(posedge clk); #1 rst = 1'b1;

        // Write then read back.
        drv(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
        #2 chk("wr_rd3", rd[31:0], 32'hDEADBEEF);
        // Write to register 0 is dropped, also during the write cycle.
        tick();
        drv(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        #2 chk("r0_bypass", rd[31:0], 32'd0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #2 chk("r0_after", rd[31:0], 32'd0);

        // Bypass.
        tick();
        drv(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drv(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd0, 5'd7);
        #2 chk("bypass_rd1", rd[63:32], 32'h22);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);
        #2 chk("post_bypass_rd1", rd[63:32], 32'h22);

        // Scoreboard set / clear.
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
        #2 chk("iss_not_visible", 32'(rd_pend[0]), 32'd0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
        #2 chk("pend4", 32'(rd_pend[0]), 32'd1);
        chk("cnt1", 32'(pend_cnt), 32'd1);
        tick();
        drv(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 5'd0);
        #2 chk("pend4_wb", 32'(rd_pend[0]), 32'd0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
        #2 chk("cnt0", 32'(pend_cnt), 32'd0);

        // Simultaneous issue and writeback on register 9: set wins.
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        tick();
        drv(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 5'd0);
        #2 chk("sim_pend9", 32'(rd_pend[0]), 32'd1);
        chk("sim_cnt", 32'(pend_cnt), 32'd1);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        #2 chk("iss0_cnt", 32'(pend_cnt), 32'd1);
        chk("iss0_pend", 32'(rd_pend[0]), 32'd0);

        // Reset mid-run, checked without a clock edge.
        tick();
        drv(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        #1 chk("pre_rst_rd5", rd[31:0], 32'h1234);
        rst = 1'b0;
        #1 chk("rst_rd5", rd[31:0], 32'd0);
        chk("rst_cnt", 32'(pend_cnt), 32'd0);
        tick();
        rst = 1'b1;

        // Randomized traffic, addresses biased toward a small set for collisions.
        for (int c = 0; c < 3000; c++) begin
            logic [AW-1:0] a0, a1, a2, a3;
            tick();
            if ($urandom_range(0, 299) == 0) rst = 1'b0;
            else rst = 1'b1;
            a0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 5)) : AW'($urandom);
            a1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 5)) : AW'($urandom);
            a2 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 5)) : AW'($urandom);
            a3 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 5)) : AW'($urandom);
            drv(1'($urandom_range(0, 1)), a0, $urandom,
                1'($urandom_range(0, 2) != 0), a1, a2, a3);
        end
        tick();
        rst = 1'b1;
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_sb.md
Name: grf_sb

Overview:
- Parametrised general register file for the pipelined CPU core; the next generation of the single-issue GRF.
- Width, depth and read-port count are generic.
- Same-cycle write-to-read bypass, so the ID stage sees WB data without an external forwarding mux.
- Per-register pending (scoreboard) bits, set at issue and cleared at writeback, feed the hazard/stall unit.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, address width; NREG = 2**ADDR_W registers
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
ra  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  read data, combinational, packed the same way as ra
rd_pend  out  NRD  pending flag for each read address, combinational
we  in  1  writeback enable
wa  in  ADDR_W  writeback address
wd  in  DATA_W  writeback data
wpc  in  32  PC of the writing instruction (trace only)
iss_en  in  1  issue enable; marks iss_addr as pending
iss_addr  in  ADDR_W  destination register of the issuing instruction
pend_cnt  out  ADDR_W+1  number of registers currently pending, registered

Behaviour:
Reset
- rst low asynchronously clears every register, every pending bit and pend_cnt to 0.
- Outputs settle combinationally: rd = 0, rd_pend = 0.
- Reset deasserted mid-stream: the first rising edge with rst high is the first normal update.

Write
- On the rising edge with we=1, R[wa] <= wd.
- With ZERO_REG=1 and wa=0 the write is dropped; R[0] stays 0.

Read, per port k (zero latency)
- ZERO_REG && ra_k==0: rd_k = 0.
- Else if we && wa==ra_k: rd_k = wd (bypass; the write wins over the stored value).
- Else: rd_k = R[ra_k].

Pending bits, updated on the rising edge
- iss_en sets pend[iss_addr].
- we clears pend[wa].
- iss_en && we && iss_addr==wa: set wins; a new producer supersedes the completing one.
- Address 0 is never set when ZERO_REG=1.
- Clearing a non-pending register is a no-op.

rd_pend_k (combinational)
- rd_pend_k = pend[ra_k] & ~(we && wa==ra_k).
- The same-cycle writeback is treated as resolved, consistent with the bypass.
- A same-cycle issue is not reflected until the next cycle.
- With ZERO_REG=1, rd_pend_k = 0 when ra_k==0.

pend_cnt
- Updated incrementally on each edge: +1 if a register goes 0→1, −1 if one goes 1→0.
- Net change per edge is −1, 0 or +1.
- Invariant: pend_cnt == popcount(pend) at all times.
- Maximum value is NREG−ZERO_REG; the width ADDR_W+1 cannot overflow.

Invalid input
- Issuing an already-pending register leaves it pending with no count change (WAW is allowed).
- Out-of-range NRD is a compile-time error, raised via an unreachable generate branch.

Optional Feature:
GRF_TRACE_EN
- Defined: on every edge with rst high, we=1, and (wa!=0 or ZERO_REG=0), print $display("@%h: $%d <= %h", wpc, wa, wd), matching the course reference trace format.
- Undefined: no display statements; wpc is unused and left unconnected in synthesis.
- Register behaviour is identical in both builds.

Test Plan:
- Reset: drive rst=0 mid-run after writing R[5]=32'h1234 → rd(ra=5)=0 immediately without a clock edge, pend_cnt=0.
- Write/read: we=1, wa=3, wd=32'hDEADBEEF, then read ra0=3 next cycle → rd0=32'hDEADBEEF; a write to wa=0 → rd(ra=0)=0.
- Bypass: R[7]=32'h11, same cycle we=1, wa=7, wd=32'h22, ra1=7 → rd1=32'h22 in that cycle; after the edge rd1=32'h22.
- Scoreboard: iss_en with iss_addr=4 → next cycle rd_pend(ra=4)=1, pend_cnt=1; then we, wa=4 → rd_pend=0 during that cycle, pend_cnt=0 after the edge.
- Simultaneous: register 9 pending, iss_en with iss_addr=9 and we with wa=9 in the same cycle → pend[9] stays 1, pend_cnt unchanged; iss_addr=0 → never pending.
- Trace: with GRF_TRACE_EN defined, we=1, wa=2, wd=32'h5, wpc=32'h3000 → log line "@00003000: $ 2 <= 00000005"; no output when undefined.
